// File: rtl/fifo_prog_status.sv
// First-word-fall-through FIFO with programmable almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow flags. Define FIFO_PEAK_EN to add peak_count.
module fifo_prog_status #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_RESET   = 2**ADDR_WIDTH - 2,
    parameter int AE_RESET   = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  thr_we,
    input  logic [ADDR_WIDTH:0]   af_thresh_in,
    input  logic [ADDR_WIDTH:0]   ae_thresh_in,
    output logic [ADDR_WIDTH:0]   count,
`ifdef FIFO_PEAK_EN
    output logic [ADDR_WIDTH:0]   peak_count,
`endif
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_INIT = AF_RESET[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_INIT = AE_RESET[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_r, rd_ptr_r;
    logic [ADDR_WIDTH:0]   af_thresh_r, ae_thresh_r;
    logic                  overflow_r, underflow_r;
    logic [ADDR_WIDTH:0]   count_s, count_next_s;
    logic                  push_s, pop_s, ovf_set_s, unf_set_s;

    assign count_s = wr_ptr_r - rd_ptr_r;

    // Handshake decode; flush masks push/pop and error detection.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        count_next_s = count_s;
        if (flush) begin
            count_next_s = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            pop_s        = rd & (count_s != {(ADDR_WIDTH+1){1'b0}});
            push_s       = wr & ((count_s != DEPTH_C) | pop_s);
            ovf_set_s    = wr & (count_s == DEPTH_C) & ~pop_s;
            unf_set_s    = rd & (count_s == {(ADDR_WIDTH+1){1'b0}});
            count_next_s = count_s + {{ADDR_WIDTH{1'b0}}, push_s} - {{ADDR_WIDTH{1'b0}}, pop_s};
        end
    end

    // Storage array: written only on an accepted push.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointers, thresholds and sticky error flags.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_r    <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_r    <= {(ADDR_WIDTH+1){1'b0}};
            af_thresh_r <= AF_INIT;
            ae_thresh_r <= AE_INIT;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
                rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (pop_s)  rd_ptr_r <= rd_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (thr_we) begin
                af_thresh_r <= af_thresh_in;
                ae_thresh_r <= ae_thresh_in;
            end
            // A set in the same cycle wins over err_clr.
            if (ovf_set_s)    overflow_r <= 1'b1;
            else if (err_clr) overflow_r <= 1'b0;
            if (unf_set_s)    underflow_r <= 1'b1;
            else if (err_clr) underflow_r <= 1'b0;
        end
    end

`ifdef FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] peak_r;

    // High-water mark of occupancy, cleared by flush or err_clr.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            peak_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (flush || err_clr) begin
            peak_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (count_next_s > peak_r) begin
            peak_r <= count_next_s;
        end
    end

    assign peak_count = peak_r;
`endif

    assign rd_data      = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    assign count        = count_s;
    assign full         = (count_s == DEPTH_C);
    assign empty        = (count_s == {(ADDR_WIDTH+1){1'b0}});
    assign almost_full  = (count_s >= af_thresh_r);
    assign almost_empty = (count_s <= ae_thresh_r);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
endmodule
